// File: rtl/conv_pkg.sv
// Shared constants and types for the conv post-processing stages.
// Defaults describe the 26x26 conv output map feeding the pooling stage.
package conv_pkg;

  localparam int unsigned DIN_W_DEF  = 32;
  localparam int unsigned DOUT_W_DEF = 16;
  localparam int unsigned IMG_W_DEF  = 26;
  localparam int unsigned IMG_H_DEF  = 26;
  localparam int unsigned SHIFT_DEF  = 8;

  // Largest positive value representable in the signed output word.
  localparam logic [DOUT_W_DEF-1:0] SAT_MAX = {1'b0, {(DOUT_W_DEF-1){1'b1}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned X_W_DEF = coord_w(IMG_W_DEF);
  localparam int unsigned Y_W_DEF = coord_w(IMG_H_DEF);

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the last even row.
// One write port, one combinational read port; storage is never reset.
module pool_line_buf #(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned W     = 16,
  parameter int unsigned A_W   = 4
) (
  input  logic           clk,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [A_W-1:0] raddr,
  output logic [W-1:0]   rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/relu_maxpool2.sv
// ReLU + shift requantisation + 16-bit saturation followed by 2x2 stride-2
// max-pooling over a raster-ordered conv output map.
module relu_maxpool2
  import conv_pkg::*;
#(
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned DOUT_W = DOUT_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  input  logic              sync_clr,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_done,
  output logic              sat_flag
);

  localparam int unsigned X_W      = coord_w(IMG_W);
  localparam int unsigned Y_W      = coord_w(IMG_H);
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned A_W      = coord_w(LB_DEPTH);

  localparam logic [DOUT_W-1:0] QMax  = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [X_W-1:0]    XLast = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    YLast = Y_W'(IMG_H - 1);

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DOUT_W-1:0] h_q, h_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sat_q, sat_d;

  logic signed [DIN_W-1:0] shifted;
  logic                    q_neg;
  logic                    q_sat;
  logic [DOUT_W-1:0]       q_val;
  logic [DOUT_W-1:0]       hmax;
  logic [DOUT_W-1:0]       lb_rdata;
  logic [DOUT_W-1:0]       pool_max;
  logic [A_W-1:0]          lb_addr;
  logic                    lb_we;
  logic                    accept;
  logic                    x_last;
  logic                    y_last;

  // ReLU, arithmetic shift, then clamp to the positive range of the output.
  always_comb begin
    shifted = $signed(din) >>> SHIFT;
    q_neg   = din[DIN_W-1];
    q_sat   = !q_neg && ($unsigned(shifted) > DIN_W'(QMax));
    if (q_neg) begin
      q_val = '0;
    end else if (q_sat) begin
      q_val = QMax;
    end else begin
      q_val = shifted[DOUT_W-1:0];
    end
  end

  assign accept   = din_valid && !sync_clr;
  assign x_last   = (x_q == XLast);
  assign y_last   = (y_q == YLast);
  assign hmax     = (q_val > h_q) ? q_val : h_q;
  assign pool_max = (lb_rdata > hmax) ? lb_rdata : hmax;
  assign lb_addr  = A_W'(x_q >> 1);

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .W     (DOUT_W),
    .A_W   (A_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Next-state: frame state, raster counters, window datapath.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    h_d          = h_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    sat_d        = sat_q;
    lb_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sync_clr || (accept && x_last && y_last)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sync_clr) begin
      x_d = '0;
      y_d = '0;
      h_d = '0;
    end else if (din_valid) begin
      sat_d = sat_q || q_sat;
      if (!x_q[0]) begin
        h_d = q_val;
      end else if (!y_q[0]) begin
        lb_we = 1'b1;
      end else begin
        dout_d       = pool_max;
        dout_valid_d = 1'b1;
      end

      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
      frame_done_d = x_last && y_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      h_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      h_q          <= h_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      sat_q        <= sat_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_relu_maxpool2.sv
// Directed bench for relu_maxpool2 on a 4x4 map, driving a SHIFT=0 and a
// SHIFT=8 instance from the same stimulus.
module tb_relu_maxpool2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        din_valid;
  logic        sync_clr;

  logic [15:0] dout0, dout8;
  logic        vld0, vld8, fd0, fd8, sat0, sat8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] fv   [16];
  logic [15:0] exp0 [4];
  logic [15:0] exp8 [4];
  logic [15:0] last0, last8;

  always #5 clk = ~clk;

  relu_maxpool2 #(
    .DIN_W(32), .DOUT_W(16), .IMG_W(4), .IMG_H(4), .SHIFT(0)
  ) u_dut_s0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sync_clr(sync_clr), .dout(dout0), .dout_valid(vld0),
    .frame_done(fd0), .sat_flag(sat0)
  );

  relu_maxpool2 #(
    .DIN_W(32), .DOUT_W(16), .IMG_W(4), .IMG_H(4), .SHIFT(8)
  ) u_dut_s8 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sync_clr(sync_clr), .dout(dout8), .dout_valid(vld8),
    .frame_done(fd8), .sat_flag(sat8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs sampled 1ns after the rise.
  task automatic cyc(input logic v, input logic [31:0] d, input logic clr);
    @(negedge clk);
    din       = d;
    din_valid = v;
    sync_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq();
    for (int k = 0; k < 16; k++) fv[k] = 32'(k + 1);
  endtask

  task automatic set_exp(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3);
    exp0[0] = a0; exp0[1] = a1; exp0[2] = a2; exp0[3] = a3;
    exp8[0] = b0; exp8[1] = b1; exp8[2] = b2; exp8[3] = b3;
  endtask

  // Window closers of a 4x4 raster are sample indices 5, 7, 13 and 15.
  task automatic run_frame(input int gap);
    int  j;
    logic pulse;
    j = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, fv[k], 1'b0);
      pulse = (k == 5) || (k == 7) || (k == 13) || (k == 15);
      check("vld0", 32'(vld0), 32'(pulse));
      check("vld8", 32'(vld8), 32'(pulse));
      if (pulse) begin
        last0 = exp0[j];
        last8 = exp8[j];
        j++;
      end
      check("dout0", 32'(dout0), 32'(last0));
      check("dout8", 32'(dout8), 32'(last8));
      check("frame_done", 32'(fd0), 32'(k == 15));
      check("frame_done8", 32'(fd8), 32'(k == 15));
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 32'hDEAD_BEEF, 1'b0);
        check("gap_vld", 32'(vld0), 32'd0);
        check("gap_fd", 32'(fd0), 32'd0);
        check("gap_dout_hold", 32'(dout0), 32'(last0));
      end
    end
  endtask

  // Partial frame that never closes a window (samples 0..4).
  task automatic partial_frame();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'(100 + k), 1'b0);
      check("pre_abort_vld", 32'(vld0), 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sync_clr  = 1'b0;
    last0     = '0;
    last8     = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(dout0), 32'd0);
    check("rst_vld", 32'(vld0), 32'd0);
    check("rst_fd", 32'(fd0), 32'd0);
    check("rst_sat0", 32'(sat0), 32'd0);
    check("rst_sat8", 32'(sat8), 32'd0);
    reset = 1'b0;

    // Ascending 1..16, back to back.
    fill_seq();
    set_exp(16'd6, 16'd8, 16'd14, 16'd16, 16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(0);
    check("seq_sat0", 32'(sat0), 32'd0);

    // All negative: ReLU forces zero.
    for (int k = 0; k < 16; k++) fv[k] = 32'hFFFF_FFFB;
    set_exp(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(0);
    check("neg_sat0", 32'(sat0), 32'd0);
    check("neg_sat8", 32'(sat8), 32'd0);

    // Saturating sample in window 0, 256 elsewhere.
    for (int k = 0; k < 16; k++) fv[k] = 32'd256;
    fv[0] = 32'h7FFF_FFFF;
    set_exp(16'd32767, 16'd256, 16'd256, 16'd256, 16'd32767, 16'd1, 16'd1, 16'd1);
    run_frame(0);
    check("sat_set0", 32'(sat0), 32'd1);
    check("sat_set8", 32'(sat8), 32'd1);

    // Ascending frame with 3 idle cycles after every sample; sat stays sticky.
    fill_seq();
    set_exp(16'd6, 16'd8, 16'd14, 16'd16, 16'd0, 16'd0, 16'd0, 16'd0);
    run_frame(3);
    check("sat_sticky8", 32'(sat8), 32'd1);

    // Abort by sync_clr with a colliding valid sample that must be discarded.
    partial_frame();
    cyc(1'b1, 32'd1000, 1'b1);
    check("clr_vld", 32'(vld0), 32'd0);
    check("clr_keeps_sat", 32'(sat0), 32'd1);
    run_frame(0);
    check("clr_sat_after", 32'(sat0), 32'd1);

    // Abort by asynchronous reset in the middle of a clock phase.
    partial_frame();
    cyc(1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_dout", 32'(dout0), 32'd0);
    check("async_vld", 32'(vld0), 32'd0);
    check("async_fd", 32'(fd0), 32'd0);
    check("async_sat0", 32'(sat0), 32'd0);
    check("async_sat8", 32'(sat8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last0 = '0;
    last8 = '0;
    run_frame(0);
    check("post_rst_sat", 32'(sat0), 32'd0);

    cyc(1'b0, 32'd0, 1'b0);
    check("tail_vld", 32'(vld0), 32'd0);
    check("tail_fd", 32'(fd0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
